// File: rtl/dma_job_scheduler.sv
// Job queue plus register-programming sequencer for the DMA engine core.
// Splits each queued copy job into engine runs of at most CHUNK_BYTES.
module dma_job_scheduler #(
  parameter int QUEUE_DEPTH = 4,
  parameter int TAG_W       = 4,
  parameter int CHUNK_BYTES = 4096,
  parameter int TIMEOUT     = 1048576
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [31:0]      job_src,
  input  logic [31:0]      job_dst,
  input  logic [31:0]      job_len,
  input  logic [TAG_W-1:0] job_tag,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [TAG_W-1:0] done_tag,
  output logic             done_err,
  input  logic             abort,
  output logic             busy,
  output logic [31:0]      reg_wr_data,
  output logic [5:0]       reg_wr_en,
  input  logic [31:0]      eng_tail_ptr,
  input  logic             eng_intr
);

  localparam int          PW         = $clog2(QUEUE_DEPTH);
  localparam logic [31:0] LP_CHUNK   = 32'(CHUNK_BYTES);
  localparam logic [31:0] LP_WD_LAST = 32'(TIMEOUT - 1);
  localparam logic [PW:0] LP_FULL    = (PW+1)'(QUEUE_DEPTH);

  typedef enum logic [3:0] {
    S_IDLE, S_LD_SRC, S_LD_DST, S_LD_TAIL, S_LD_HEAD,
    S_LD_SIZE, S_START, S_WAIT, S_STOP, S_DONE
  } state_t;

  state_t           r_state;
  logic [31:0]      r_q_src [QUEUE_DEPTH];
  logic [31:0]      r_q_dst [QUEUE_DEPTH];
  logic [31:0]      r_q_len [QUEUE_DEPTH];
  logic [TAG_W-1:0] r_q_tag [QUEUE_DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [PW:0]      r_count;
  logic             r_job_ready;
  logic [31:0]      r_rem;
  logic [31:0]      r_wd;
  logic             r_err;

  logic             w_push, w_pop;
  logic [PW:0]      w_count_nxt;
  logic [31:0]      w_len_masked;
  logic [31:0]      w_head_src, w_head_dst, w_head_len;
  logic [TAG_W-1:0] w_head_tag;
  logic [31:0]      w_chunk, w_rem_stop;
  logic             w_abortable;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  assign w_push       = job_valid & r_job_ready;
  assign w_pop        = (r_state == S_DONE) & done_ready;
  assign w_len_masked = job_len & 32'hFFFF_FFFC;

  assign w_head_src = r_q_src[r_rd_ptr];
  assign w_head_dst = r_q_dst[r_rd_ptr];
  assign w_head_len = r_q_len[r_rd_ptr];
  assign w_head_tag = r_q_tag[r_rd_ptr];

  assign w_chunk    = (r_rem > LP_CHUNK) ? LP_CHUNK : r_rem;
  // A tail pointer beyond the job length is an engine fault; treat the job as finished.
  assign w_rem_stop = (eng_tail_ptr > w_head_len) ? 32'd0 : (w_head_len - eng_tail_ptr);
  assign w_abortable = (r_state != S_IDLE) && (r_state != S_STOP) && (r_state != S_DONE);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + (PW+1)'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - (PW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_src[r_wr_ptr] <= job_src;
      r_q_dst[r_wr_ptr] <= job_dst;
      r_q_len[r_wr_ptr] <= w_len_masked;
      r_q_tag[r_wr_ptr] <= job_tag;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_job_ready <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count     <= w_count_nxt;
      r_job_ready <= (w_count_nxt != LP_FULL);
    end
  end

  // The head job stays queued until its completion record is consumed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_wd    <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_count != '0) begin
            r_rem   <= w_head_len;
            r_state <= (w_head_len == '0) ? S_DONE : S_LD_SRC;
          end
        end
        S_LD_SRC:  r_state <= S_LD_DST;
        S_LD_DST:  r_state <= S_LD_TAIL;
        S_LD_TAIL: r_state <= S_LD_HEAD;
        S_LD_HEAD: r_state <= S_LD_SIZE;
        S_LD_SIZE: r_state <= S_START;
        S_START: begin
          r_wd    <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_wd <= r_wd + 32'd1;
          if (eng_intr) begin
            r_state <= S_STOP;
          end else if ((TIMEOUT != 0) && (r_wd == LP_WD_LAST)) begin
            r_state <= S_STOP;
            r_err   <= 1'b1;
          end
        end
        S_STOP: begin
          r_rem   <= w_rem_stop;
          r_state <= (r_err || (w_rem_stop == '0)) ? S_DONE : S_LD_SIZE;
        end
        S_DONE: begin
          if (done_ready) begin
            r_err   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_abortable && abort) begin
        r_state <= S_STOP;
        r_err   <= 1'b1;
      end
    end
  end

  always_comb begin
    reg_wr_en   = 6'b000000;
    reg_wr_data = 32'd0;
    case (r_state)
      S_LD_SRC:  begin reg_wr_en = 6'b000001; reg_wr_data = w_head_src; end
      S_LD_DST:  begin reg_wr_en = 6'b000010; reg_wr_data = w_head_dst; end
      S_LD_TAIL: begin reg_wr_en = 6'b000100; reg_wr_data = 32'd0;      end
      S_LD_HEAD: begin reg_wr_en = 6'b001000; reg_wr_data = w_head_len; end
      S_LD_SIZE: begin reg_wr_en = 6'b010000; reg_wr_data = w_chunk;    end
      S_START:   begin reg_wr_en = 6'b100000; reg_wr_data = 32'h1;      end
      S_STOP:    begin reg_wr_en = 6'b100000; reg_wr_data = 32'h0;      end
      default:   begin reg_wr_en = 6'b000000; reg_wr_data = 32'd0;      end
    endcase
  end

  assign job_ready  = r_job_ready;
  assign done_valid = (r_state == S_DONE);
  assign done_tag   = done_valid ? w_head_tag : '0;
  assign done_err   = done_valid & r_err;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_dma_job_scheduler.sv
// Directed bench for dma_job_scheduler with a small behavioural engine model
// that advances tail_ptr by the programmed size and raises its interrupt.
module tb_dma_job_scheduler;

  localparam int TW = 4;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [31:0]   job_src = '0, job_dst = '0, job_len = '0;
  logic [TW-1:0] job_tag = '0;
  logic          done_valid;
  logic          done_ready = 1'b0;
  logic [TW-1:0] done_tag;
  logic          done_err;
  logic          abort = 1'b0;
  logic          busy;
  logic [31:0]   reg_wr_data;
  logic [5:0]    reg_wr_en;
  logic [31:0]   eng_tail_ptr = '0;
  logic          eng_intr = 1'b0;

  dma_job_scheduler #(.QUEUE_DEPTH(4), .TAG_W(TW), .CHUNK_BYTES(4096), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_src(job_src), .job_dst(job_dst), .job_len(job_len), .job_tag(job_tag),
    .done_valid(done_valid), .done_ready(done_ready), .done_tag(done_tag), .done_err(done_err),
    .abort(abort), .busy(busy),
    .reg_wr_data(reg_wr_data), .reg_wr_en(reg_wr_en),
    .eng_tail_ptr(eng_tail_ptr), .eng_intr(eng_intr)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- engine model and register-write log ----------------
  logic [31:0] log_data[$];
  logic [5:0]  log_en[$];
  int          log_cyc[$];
  logic        stall = 1'b0;
  logic        armed = 1'b0;
  int          ecnt = 0;
  logic [31:0] esize = '0;

  always @(negedge clk) begin
    if (!resetn) begin
      eng_intr     = 1'b0;
      eng_tail_ptr = '0;
      armed        = 1'b0;
    end else begin
      if (reg_wr_en != 6'b0) begin
        log_data.push_back(reg_wr_data);
        log_en.push_back(reg_wr_en);
        log_cyc.push_back(cyc);
      end
      if (reg_wr_en[2]) eng_tail_ptr = reg_wr_data;
      if (reg_wr_en[4]) esize = reg_wr_data;
      if (reg_wr_en[5]) begin
        if (reg_wr_data == 32'h1) begin
          armed = 1'b1;
          ecnt  = 0;
        end else begin
          armed    = 1'b0;
          eng_intr = 1'b0;
        end
      end else if (armed && !stall) begin
        ecnt++;
        if (ecnt == 3) begin
          eng_tail_ptr = eng_tail_ptr + esize;
          eng_intr     = 1'b1;
          armed        = 1'b0;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [5:0]  exp_en_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    log_data.delete();
    log_en.delete();
    log_cyc.delete();
  endtask

  task automatic compare_log(input string name);
    check({name, "_nwrites"}, 32'(log_data.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_data.size(); i++) begin
      check($sformatf("%s_wr%0d_en", name, i), 32'(log_en[i]), 32'(exp_en_q[i]));
      check($sformatf("%s_wr%0d_data", name, i), log_data[i], exp_q[i]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_job(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                          input logic [TW-1:0] t, output int pc);
    int p = -1;
    job_src = s; job_dst = d; job_len = l; job_tag = t;
    job_valid = 1'b1;
    for (int i = 0; i < 1000 && p < 0; i++) begin
      if (job_ready) begin
        @(negedge clk);
        p = cyc;
      end else begin
        @(negedge clk);
      end
    end
    job_valid = 1'b0;
    check("push_accepted", 32'(p >= 0), 32'd1);
    pc = p;
  endtask

  task automatic wait_done(input logic [TW-1:0] t, input logic e, output int dc);
    int d = -1;
    for (int i = 0; i < 3000 && d < 0; i++) begin
      if (done_valid) d = cyc;
      else @(negedge clk);
    end
    check("done_seen", 32'(d >= 0), 32'd1);
    if (d >= 0) begin
      check("done_tag", 32'(done_tag), 32'(t));
      check("done_err", 32'(done_err), 32'(e));
      done_ready = 1'b1;
      @(negedge clk);
      done_ready = 1'b0;
    end
    dc = d;
  endtask

  task automatic wait_start_logged();
    for (int i = 0; i < 200 && log_en.size() < 6; i++) @(negedge clk);
    check("start_logged", 32'(log_en.size() >= 6), 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0]   src;
    logic [31:0]   dst;
    logic [31:0]   len;
    logic [TW-1:0] tag;
    logic [31:0]   hlen;     // value expected in the head register write
    int            n_chunks;
    logic [31:0]   last_sz;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int pc, dc, d1, pc5, ab_cyc;
    int pcs[4];

    vecs[0] = '{src:32'h1000,  dst:32'h2000,  len:32'h2000, tag:4'd3,  hlen:32'h2000, n_chunks:2, last_sz:32'h1000};
    vecs[1] = '{src:32'h4000,  dst:32'h5000,  len:32'h1800, tag:4'd5,  hlen:32'h1800, n_chunks:2, last_sz:32'h0800};
    vecs[2] = '{src:32'h0100,  dst:32'h0200,  len:32'h0044, tag:4'd7,  hlen:32'h0044, n_chunks:1, last_sz:32'h0044};
    vecs[3] = '{src:32'h0300,  dst:32'h0400,  len:32'h1003, tag:4'd9,  hlen:32'h1000, n_chunks:1, last_sz:32'h1000};
    vecs[4] = '{src:32'h10000, dst:32'h20000, len:32'h3000, tag:4'hC, hlen:32'h3000, n_chunks:3, last_sz:32'h1000};

    // reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_en", 32'(reg_wr_en), 32'd0);
    check("rst_wr_data", reg_wr_data, 32'd0);
    check("rst_done_valid", 32'(done_valid), 32'd0);
    check("rst_done_tag", 32'(done_tag), 32'd0);
    check("rst_done_err", 32'(done_err), 32'd0);
    check("rst_job_ready", 32'(job_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    check("rel_job_ready_low", 32'(job_ready), 32'd0);
    @(negedge clk);
    check("rel_job_ready_high", 32'(job_ready), 32'd1);

    // table-driven jobs: full register write sequence and completion record
    for (int v = 0; v < 5; v++) begin
      clear_log();
      push_job(vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].tag, pc);
      wait_done(vecs[v].tag, 1'b0, dc);
      @(negedge clk);
      exp_q.delete(); exp_en_q.delete();
      exp_q.push_back(vecs[v].src);  exp_en_q.push_back(6'h01);
      exp_q.push_back(vecs[v].dst);  exp_en_q.push_back(6'h02);
      exp_q.push_back(32'h0);        exp_en_q.push_back(6'h04);
      exp_q.push_back(vecs[v].hlen); exp_en_q.push_back(6'h08);
      for (int c = 0; c < vecs[v].n_chunks; c++) begin
        exp_q.push_back((c == vecs[v].n_chunks - 1) ? vecs[v].last_sz : 32'h1000);
        exp_en_q.push_back(6'h10);
        exp_q.push_back(32'h1); exp_en_q.push_back(6'h20);
        exp_q.push_back(32'h0); exp_en_q.push_back(6'h20);
      end
      compare_log($sformatf("vec%0d", v));
      if (v == 0 && log_cyc.size() >= 9) begin
        check("lat_ld_src", 32'(log_cyc[0] - pc), 32'd1);
        check("lat_start", 32'(log_cyc[5] - pc), 32'd6);
        check("lat_rearm", 32'(log_cyc[8] - log_cyc[6]), 32'd2);
      end
    end

    // zero-length job: straight to DONE, no engine writes
    clear_log();
    push_job(32'h7000, 32'h8000, 32'h0, 4'hA, pc);
    wait_done(4'hA, 1'b0, dc);
    check("len0_done_lat", 32'(dc - pc), 32'd1);
    @(negedge clk);
    check("len0_no_writes", 32'(log_data.size()), 32'd0);

    // queue full with stalled engine; first job times out, fifth waits for the first pop
    clear_log();
    stall = 1'b1;
    fork
      begin
        for (int j = 0; j < 4; j++)
          push_job(32'h100 * j, 32'h9000 + 32'h100 * j, 32'h40, TW'(j + 1), pcs[j]);
        check("push_back_to_back", 32'(pcs[3] - pcs[0]), 32'd3);
        for (int k = 0; k < 3; k++) begin
          check("full_job_ready", 32'(job_ready), 32'd0);
          @(negedge clk);
        end
        push_job(32'h500, 32'h9500, 32'h40, 4'd5, pc5);
      end
      begin
        wait_done(4'd1, 1'b1, d1);
        stall = 1'b0;
        for (int j = 2; j <= 5; j++) wait_done(TW'(j), 1'b0, dc);
      end
    join
    check("fifth_push_after_pop", 32'(pc5 - d1), 32'd2);
    if (log_en.size() >= 7) begin
      check("timeout_stop_en", 32'(log_en[6]), 32'h20);
      check("timeout_stop_data", log_data[6], 32'h0);
      // START cycle followed by TO cycles in WAIT before STOP
      check("timeout_stop_lat", 32'(log_cyc[6] - log_cyc[5]), 32'(TO + 1));
    end else begin
      check("timeout_log_size", 32'(log_en.size()), 32'd7);
    end

    // abort while waiting on the engine
    clear_log();
    stall = 1'b1;
    push_job(32'hA000, 32'hB000, 32'h40, 4'd6, pc);
    wait_start_logged();
    repeat (5) @(negedge clk);
    abort = 1'b1;
    ab_cyc = cyc;
    @(negedge clk);
    abort = 1'b0;
    wait_done(4'd6, 1'b1, dc);
    @(negedge clk);
    check("abort_nwrites", 32'(log_data.size()), 32'd7);
    if (log_en.size() >= 7) begin
      check("abort_stop_en", 32'(log_en[6]), 32'h20);
      check("abort_stop_data", log_data[6], 32'h0);
      check("abort_stop_lat", 32'(log_cyc[6] - ab_cyc), 32'd1);
    end

    // asynchronous reset in WAIT, then queue must be empty
    clear_log();
    push_job(32'hC000, 32'hD000, 32'h40, 4'd7, pc);
    wait_start_logged();
    repeat (5) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_wr_en", 32'(reg_wr_en), 32'd0);
    check("async_rst_done_valid", 32'(done_valid), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    stall = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_job_ready", 32'(job_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check("post_rst_idle", 32'(busy), 32'd0);
      @(negedge clk);
    end
    push_job(32'hE000, 32'hF000, 32'h40, 4'd8, pc);
    wait_done(4'd8, 1'b0, dc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
